// File: rtl/clk_div_cfg_ctrl.sv
// Sequences run-time reprogramming of a configurable clock divider: park the output mux on
// refclk, load the new ratio, wait for the divider to settle, then reselect the divided clock.
module clk_div_cfg_ctrl #(
    parameter int unsigned MAX_DIV      = 64,
    parameter int unsigned RESET_HDIV   = 0,
    parameter int unsigned SEL_WAIT     = 4,
    parameter int unsigned SETTLE_EXTRA = 4,
    localparam int unsigned W           = $clog2(MAX_DIV)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_req,
    input  logic [W-1:0] cfg_half_div_less_1,
    input  logic         cfg_bypass,
    input  logic         dft_en,
    output logic         cfg_ack,
    output logic         cfg_busy,
    output logic [W-1:0] half_div_less_1,
    output logic         divclk_sel
);

    localparam int unsigned CntW = $clog2(2 * MAX_DIV + SETTLE_EXTRA + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDesel  = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StSettle = 3'd3;
    localparam logic [2:0] StResel  = 3'd4;
    localparam logic [2:0] StAck    = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    nd_q, nd_d;
    logic            bp_q, bp_d;
    logic [W-1:0]    hdiv_q, hdiv_d;
    logic            sel_q, sel_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [CntW-1:0] settle_m1;

    // S - 1 = 2*(nd+1) + SETTLE_EXTRA - 1 = 2*nd + SETTLE_EXTRA + 1
    assign settle_m1 = (CntW'(nd_q) << 1) + CntW'(SETTLE_EXTRA + 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nd_d    = nd_q;
        bp_d    = bp_q;
        hdiv_d  = hdiv_q;
        sel_d   = sel_q;
        case (state_q)
            StIdle: begin
                if (cfg_req && !dft_en) begin
                    nd_d = cfg_half_div_less_1;
                    bp_d = cfg_bypass;
                    // Already running the requested ratio on the divided clock: nothing to do.
                    if (!cfg_bypass && (cfg_half_div_less_1 == hdiv_q) && sel_q) begin
                        state_d = StAck;
                    end else begin
                        state_d = StDesel;
                        sel_d   = 1'b0;
                        cnt_d   = CntW'(SEL_WAIT - 1);
                    end
                end
            end
            StDesel: begin
                if (cnt_q == '0) begin
                    state_d = bp_q ? StAck : StLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLoad: begin
                hdiv_d  = nd_q;
                cnt_d   = settle_m1;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StResel;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResel: begin
                sel_d   = 1'b1;
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ack_d  = (state_d == StAck);
    assign busy_d = (state_d != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nd_q    <= '0;
            bp_q    <= 1'b0;
            hdiv_q  <= W'(RESET_HDIV);
            sel_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nd_q    <= nd_d;
            bp_q    <= bp_d;
            hdiv_q  <= hdiv_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign cfg_ack         = ack_q;
    assign cfg_busy        = busy_q;
    assign half_div_less_1 = hdiv_q;
    // DFT forces refclk without disturbing the sequence in flight.
    assign divclk_sel      = sel_q & ~dft_en;

endmodule

// File: doc/clk_div_cfg_ctrl.md
# clk_div_cfg_ctrl

Controller that sequences run-time reprogramming of a configurable clock divider. It sits in the clock-control block, in front of the divider's `half_div_less_1` and `divclk_sel` inputs. A requester asks for a new divide ratio (or refclk bypass) through a req/ack handshake. The controller then steers the output mux to refclk, loads the new ratio, waits for the divider to settle, and reselects the divided clock, so no runt pulse reaches downstream logic.

## Interface
- `MAX_DIV`, 64: maximum divide ratio; ratio field width `W = $clog2(MAX_DIV)`.
- `RESET_HDIV`, 0: reset value of `half_div_less_1`.
- `SEL_WAIT`, 4: cycles held on refclk before the ratio changes (≥1).
- `SETTLE_EXTRA`, 4: extra settle cycles added after a load (≥0).
- `clk` input 1: controller clock; the same clock as the divider's refclk.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `cfg_req` input 1: level request; its fields are sampled when accepted.
- `cfg_half_div_less_1` input W: requested half-divide minus one.
- `cfg_bypass` input 1: 1 = finish on refclk (ratio not loaded).
- `dft_en` input 1: DFT mode; blocks acceptance and forces refclk selection.
- `cfg_ack` output 1: one-cycle completion pulse.
- `cfg_busy` output 1: high in every state except IDLE.
- `half_div_less_1` output W: registered ratio to the divider.
- `divclk_sel` output 1: to the divider mux; 1 = divided clock, 0 = refclk.

## Operation
- States: IDLE, DESEL, LOAD, SETTLE, RESEL, ACK. All state, counter and output registers reset asynchronously.
- Reset values:
  - state = IDLE
  - `half_div_less_1` = RESET_HDIV
  - internal select register `sel_q` = 0
  - `cfg_ack` = 0, `cfg_busy` = 0
- `divclk_sel` = `sel_q & ~dft_en`. This is the only combinational output.
- IDLE:
  - Accepts a request when `cfg_req` = 1 and `dft_en` = 0. On accept, it captures `cfg_half_div_less_1` into `nd_q` and `cfg_bypass` into `bp_q`.
  - No-op case: if `bp_q` = 0, `nd_q` equals `half_div_less_1`, and `sel_q` = 1, the next state is ACK.
  - Otherwise the next state is DESEL, `sel_q` is cleared to 0, and the counter is loaded with SEL_WAIT-1.
- DESEL: decrements the counter. At 0, the next state is ACK if `bp_q` = 1, otherwise LOAD.
- LOAD (1 cycle):
  - `half_div_less_1 <= nd_q`.
  - The counter is loaded with S-1, where S = 2*(nd_q+1) + SETTLE_EXTRA.
  - Counter width is `$clog2(2*MAX_DIV+SETTLE_EXTRA+1)`, so no overflow is possible at `nd_q` = MAX_DIV-1.
  - Next state is SETTLE.
- SETTLE: decrements the counter; at 0, the next state is RESEL.
- RESEL (1 cycle): `sel_q <= 1`; next state is ACK.
- ACK (1 cycle): `cfg_ack` = 1; next state is IDLE. The requester drops `cfg_req` in the ACK cycle. If `cfg_req` is still high in the following IDLE cycle, it is a new request.
- Requests and `cfg_*` field changes outside IDLE are ignored; the fields captured at accept are used.
- `dft_en` asserted mid-sequence: the FSM continues unchanged and only `divclk_sel` is forced to 0. `dft_en` held in IDLE: requests wait and no ack is given.
- `rst_n` asserted mid-sequence: everything returns to its reset value immediately. No ack is issued for the aborted request.

## Timing
- Cycle numbering: c0 is the IDLE cycle in which the request is accepted.
- Full sequence:
  - `cfg_busy` and `sel_q` = 0 visible from c1.
  - DESEL occupies c1..c(SEL_WAIT).
  - LOAD at c(SEL_WAIT+1); new `half_div_less_1` visible from c(SEL_WAIT+2).
  - SETTLE occupies c(SEL_WAIT+2)..c(SEL_WAIT+1+S).
  - RESEL at c(SEL_WAIT+S+2).
  - ACK at c(SEL_WAIT+S+3); `divclk_sel` = 1 is already visible in the ACK cycle.
- Bypass: ACK at c(SEL_WAIT+1); `divclk_sel` stays 0.
- No-op: ACK at c1; outputs unchanged.
- Back-to-back requests: the earliest next accept is the cycle after ACK.
- Minimum spacing between ratio change and reselect is S cycles. `divclk_sel` never changes in the same cycle as `half_div_less_1`.

## Test plan
- Reset (defaults): assert `rst_n` = 0 → `half_div_less_1` = 0, `divclk_sel` = 0, `cfg_ack` = 0, `cfg_busy` = 0. Release → FSM in IDLE.
- Ratio change (defaults): request with `cfg_half_div_less_1` = 3, bypass 0, at c0 → `divclk_sel` = 0 from c1, `half_div_less_1` = 3 from c6, `divclk_sel` = 1 and `cfg_ack` = 1 at c19, `cfg_busy` = 0 at c20.
- Bypass then no-op:
  - From a locked ratio of 3, request bypass → `cfg_ack` at c5, ratio still 3, `divclk_sel` stays 0.
  - Next request for ratio 3 with bypass 0 → full sequence (because `sel_q` = 0), ack at c19.
  - Immediately repeat the same request → no-op, ack at c1.
- Max ratio: request `cfg_half_div_less_1` = 63 → S = 132, ack at c139, counter does not wrap.
- DFT:
  - `dft_en` = 1 with `cfg_req` held → no accept, `cfg_busy` = 0. Drop `dft_en` → accept next cycle.
  - Raise `dft_en` during SETTLE → `divclk_sel` = 0 immediately, ack timing unchanged.
- Reset mid-sequence: assert `rst_n` during SETTLE → outputs return to reset values immediately, no `cfg_ack` ever pulses. A fresh request after reset completes normally.
